// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder: {cout,sum} = a + b + cin.
// Ports: clk, rst_n (async low), a/b [WIDTH], cin -> sum [WIDTH], cout (1-cycle).
module cla_adder #(
  parameter int WIDTH = 4,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NG = (GROUP > 0) ? WIDTH / GROUP : 1;

  generate
    if (WIDTH < 1 || GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_param
      $error("cla_adder: WIDTH must be a positive multiple of GROUP");
    end
  endgenerate

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] c;
  logic [NG-1:0]    pg;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gc;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  always_comb begin
    p = a ^ b;
    g = a & b;
  end

  // Group generate is a flat OR of g[m] qualified by all p above it.
  always_comb begin
    logic t;
    pg = '1;
    gg = '0;
    t  = 1'b0;
    for (int k = 0; k < NG; k++) begin
      for (int m = 0; m < GROUP; m++) begin
        pg[k] = pg[k] & p[k*GROUP+m];
        t = g[k*GROUP+m];
        for (int n = m + 1; n < GROUP; n++) begin
          t = t & p[k*GROUP+n];
        end
        gg[k] = gg[k] | t;
      end
    end
  end

  // Second level: each group carry-in is a flat SOP of pg/gg and cin.
  always_comb begin
    logic t;
    gc = '0;
    t  = 1'b0;
    for (int j = 0; j < NG; j++) begin
      t = cin;
      for (int n = 0; n < j; n++) begin
        t = t & pg[n];
      end
      gc[j] = t;
      for (int m = 0; m < j; m++) begin
        t = gg[m];
        for (int n = m + 1; n < j; n++) begin
          t = t & pg[n];
        end
        gc[j] = gc[j] | t;
      end
    end
  end

  // In-group carries built only from this group's g/p and its carry-in.
  always_comb begin
    logic t;
    c = '0;
    t = 1'b0;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        t = gc[k];
        for (int n = 0; n < j; n++) begin
          t = t & p[k*GROUP+n];
        end
        c[k*GROUP+j] = t;
        for (int m = 0; m < j; m++) begin
          t = g[k*GROUP+m];
          for (int n = m + 1; n < j; n++) begin
            t = t & p[k*GROUP+n];
          end
          c[k*GROUP+j] = c[k*GROUP+j] | t;
        end
      end
    end
  end

  always_comb begin
    sum_d  = p ^ c;
    cout_d = gg[NG-1] | (pg[NG-1] & gc[NG-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_d;
      cout <= cout_d;
    end
  end

endmodule

// File: tb/tb_cla_adder.sv
// Directed and sweep bench for cla_adder (WIDTH=4 and WIDTH=16 instances).
// Results sampled 1ns after the rising edge that captured the operands.
module tb_cla_adder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        cin;
  logic [3:0]  sum;
  logic        cout;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        cin16;
  logic [15:0] sum16;
  logic        cout16;

  int checks;
  int errors;

  cla_adder #(.WIDTH(4), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .cin(cin), .sum(sum), .cout(cout)
  );

  cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16),
    .cin(cin16), .sum(sum16), .cout(cout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] got,
                     input logic [16:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] xa, input logic [3:0] xb,
                      input logic xc, input logic [4:0] exp,
                      input string tag);
    @(negedge clk);
    a = xa; b = xb; cin = xc;
    @(posedge clk);
    #1;
    chk(tag, {12'h0, cout, sum}, {12'h0, exp});
  endtask

  initial begin
    logic [4:0]  e5;
    logic [16:0] e17;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    a = 4'hF; b = 4'hF; cin = 1'b1;
    a16 = '0; b16 = '0; cin16 = 1'b0;

    #1;
    chk("reset_t0", {12'h0, cout, sum}, 17'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", {12'h0, cout, sum}, 17'h0);
    end
    chk("reset16", {cout16, sum16}, 17'h0);

    // release with operands F+F+1 present -> 1F on first edge
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_load", {12'h0, cout, sum}, 17'h1F);

    // async clear between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", {12'h0, cout, sum}, 17'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step(4'h1, 4'h1, 1'b0, 5'h02, "nc_1_1");
    step(4'h2, 4'h3, 1'b0, 5'h05, "nc_2_3");
    step(4'h5, 4'h2, 1'b0, 5'h07, "nc_5_2");
    step(4'h1, 4'h1, 1'b1, 5'h03, "ci_1_1");
    step(4'h3, 4'h3, 1'b1, 5'h07, "ci_3_3");
    step(4'hF, 4'h1, 1'b0, 5'h10, "ov_F_1");
    step(4'hF, 4'hF, 1'b0, 5'h1E, "ov_F_F");
    step(4'hF, 4'hF, 1'b1, 5'h1F, "ov_F_F_1");
    step(4'hC, 4'h3, 1'b1, 5'h10, "ov_C_3_1");
    step(4'hA, 4'h5, 1'b0, 5'h0F, "pr_A_5");

    // back-to-back: each cycle's result, then hold until next edge
    step(4'h4, 4'h4, 1'b0, 5'h08, "b2b_0");
    step(4'h9, 4'h8, 1'b1, 5'h12, "b2b_1");
    step(4'h0, 4'h0, 1'b0, 5'h00, "b2b_2");
    step(4'h7, 4'h6, 1'b1, 5'h0E, "b2b_3");
    @(negedge clk);
    a = 4'h1; b = 4'h2; cin = 1'b0;
    #2;
    chk("hold", {12'h0, cout, sum}, 17'h0E);
    @(posedge clk);
    #1;
    chk("after_hold", {12'h0, cout, sum}, 17'h03);

    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      a = i[3:0]; b = i[7:4]; cin = i[8];
      e5 = {1'b0, i[3:0]} + {1'b0, i[7:4]} + {4'h0, i[8]};
      @(posedge clk);
      #1;
      chk("sweep4", {12'h0, cout, sum}, {12'h0, e5});
    end

    // directed 16-bit corners, then random
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1;
    @(posedge clk);
    #1;
    chk("w16_fullprop", {cout16, sum16}, 17'h10000);
    @(negedge clk);
    a16 = 16'h0FFF; b16 = 16'h0001; cin16 = 1'b0;
    @(posedge clk);
    #1;
    chk("w16_grpcarry", {cout16, sum16}, 17'h01000);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      cin16 = 1'($urandom);
      e17 = {1'b0, a16} + {1'b0, b16} + {16'h0, cin16};
      @(posedge clk);
      #1;
      chk("rand16", {cout16, sum16}, e17);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
